// File: rtl/image_pipe_gain_stage.sv
// Streaming pixel gain/offset/clip stage: Q4.8 gain with round-half-up, signed offset,
// saturation, fixed 2-cycle latency, and a small CPU register port.
module image_pipe_gain_stage #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned GAIN_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sof,
    input  logic              s_eol,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sof,
    output logic              m_eol,
    input  logic [2:0]        cpu_addr,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    input  logic [15:0]       cpu_wdata,
    output logic [15:0]       cpu_rdata,
    output logic              cpu_rvalid
);
    localparam int unsigned GAIN_FRAC = 8;
    localparam int unsigned OFF_W     = DATA_W + 1;
    localparam int unsigned PROD_W    = DATA_W + GAIN_W;
    localparam int unsigned RND_W     = PROD_W + 1 - GAIN_FRAC;
    localparam int unsigned SUM_W     = PROD_W + 2;

    localparam logic [GAIN_W-1:0] GAIN_ONE = GAIN_W'(1 << GAIN_FRAC);
    localparam logic [PROD_W:0]   RND_HALF = (PROD_W + 1)'(1 << (GAIN_FRAC - 1));

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_GAIN   = 3'd1;
    localparam logic [2:0] ADDR_OFFSET = 3'd2;
    localparam logic [2:0] ADDR_FCNT   = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd4;

    // Programmed registers and the per-frame working copies.
    logic              en_q;
    logic [GAIN_W-1:0] gain_q;
    logic [OFF_W-1:0]  offset_q;
    logic [15:0]       frame_cnt_q;
    logic              sh_en_q;
    logic [GAIN_W-1:0] sh_gain_q;
    logic [OFF_W-1:0]  sh_offset_q;

    // Stage 1
    logic              s1_valid_q;
    logic [PROD_W-1:0] s1_prod_q;
    logic [DATA_W-1:0] s1_data_q;
    logic              s1_bypass_q;
    logic [OFF_W-1:0]  s1_offset_q;
    logic              s1_sof_q;
    logic              s1_eol_q;

    logic              advance;
    logic              accept;
    logic              sof_load;
    logic              cur_en;
    logic [GAIN_W-1:0] cur_gain;
    logic [OFF_W-1:0]  cur_offset;
    logic              clr;

    logic [PROD_W:0]   prod_rnd;
    logic [RND_W-1:0]  rounded;
    logic [SUM_W-1:0]  sum;
    logic [DATA_W-1:0] pix_out;
    logic [15:0]       rd_mux;
    logic              unused_bits;

    assign advance  = !m_valid || m_ready;
    assign s_ready  = advance;
    assign accept   = s_valid && advance;
    assign sof_load = accept && s_sof;

    // The sof beat itself already runs with freshly latched settings.
    assign cur_en     = sof_load ? en_q : sh_en_q;
    assign cur_gain   = sof_load ? gain_q : sh_gain_q;
    assign cur_offset = sof_load ? offset_q : sh_offset_q;

    assign clr = cpu_wr && (cpu_addr == ADDR_CTRL) && cpu_wdata[1];

    assign prod_rnd = {1'b0, s1_prod_q} + RND_HALF;
    assign rounded  = prod_rnd[PROD_W:GAIN_FRAC];
    assign sum      = {{(SUM_W - RND_W){1'b0}}, rounded}
                    + {{(SUM_W - OFF_W){s1_offset_q[OFF_W-1]}}, s1_offset_q};

    assign unused_bits = ^{prod_rnd[GAIN_FRAC-1:0], cpu_wdata[15:GAIN_W]};

    always_comb begin
        pix_out = sum[DATA_W-1:0];
        if (sum[SUM_W-1]) begin
            pix_out = '0;
        end else if (|sum[SUM_W-2:DATA_W]) begin
            pix_out = '1;
        end
        if (s1_bypass_q) begin
            pix_out = s1_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q        <= 1'b0;
            gain_q      <= GAIN_ONE;
            offset_q    <= '0;
            frame_cnt_q <= '0;
            sh_en_q     <= 1'b0;
            sh_gain_q   <= GAIN_ONE;
            sh_offset_q <= '0;
        end else begin
            if (cpu_wr) begin
                case (cpu_addr)
                    ADDR_CTRL:   en_q     <= cpu_wdata[0];
                    ADDR_GAIN:   gain_q   <= cpu_wdata[GAIN_W-1:0];
                    ADDR_OFFSET: offset_q <= cpu_wdata[OFF_W-1:0];
                    default:     ;
                endcase
            end
            // Clear wins over a coincident sof increment.
            if (clr) begin
                frame_cnt_q <= '0;
            end else if (sof_load) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (sof_load) begin
                sh_en_q     <= en_q;
                sh_gain_q   <= gain_q;
                sh_offset_q <= offset_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_prod_q   <= '0;
            s1_data_q   <= '0;
            s1_bypass_q <= 1'b1;
            s1_offset_q <= '0;
            s1_sof_q    <= 1'b0;
            s1_eol_q    <= 1'b0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_sof       <= 1'b0;
            m_eol       <= 1'b0;
        end else if (advance) begin
            s1_valid_q  <= s_valid;
            s1_prod_q   <= PROD_W'(s_data) * PROD_W'(cur_gain);
            s1_data_q   <= s_data;
            s1_bypass_q <= !cur_en;
            s1_offset_q <= cur_offset;
            s1_sof_q    <= s_sof;
            s1_eol_q    <= s_eol;
            m_valid     <= s1_valid_q;
            m_data      <= pix_out;
            m_sof       <= s1_sof_q;
            m_eol       <= s1_eol_q;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (cpu_addr)
            ADDR_CTRL:   rd_mux = {15'd0, en_q};
            ADDR_GAIN:   rd_mux = 16'(gain_q);
            ADDR_OFFSET: rd_mux = 16'(offset_q);
            ADDR_FCNT:   rd_mux = frame_cnt_q;
            ADDR_STATUS: rd_mux = {15'd0, s1_valid_q || m_valid};
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            cpu_rvalid <= cpu_rd;
            cpu_rdata  <= cpu_rd ? rd_mux : 16'd0;
        end
    end

endmodule

// File: tb/tb_image_pipe_gain_stage.sv
// Randomised and directed bench for image_pipe_gain_stage, checked against a
// transaction-level model of the gain/offset/clip arithmetic and register map.
module tb_image_pipe_gain_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_sof;
    logic        s_eol;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_sof;
    logic        m_eol;
    logic [2:0]  cpu_addr;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_rvalid;

    image_pipe_gain_stage #(
        .DATA_W(8),
        .GAIN_W(12)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_sof      (s_sof),
        .s_eol      (s_eol),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_sof      (m_sof),
        .m_eol      (m_eol),
        .cpu_addr   (cpu_addr),
        .cpu_wr     (cpu_wr),
        .cpu_rd     (cpu_rd),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       sof;
        logic       eol;
        int         c;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mdl_en, mdl_gain, mdl_off, mdl_fcnt;
    int          sh_en, sh_gain, sh_off;
    logic        exp_rv;
    logic [15:0] exp_rd;
    bit          prev_stall;
    logic [7:0]  prev_d;
    logic        prev_sof, prev_eol;
    bit          rand_ready, chk_lat, last_accept;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h want=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_pix(input int pix, input int en, input int gain,
                                           input int off9);
        int off;
        int s;
        if (en == 0) return 8'(pix);
        off = (off9 >= 256) ? off9 - 512 : off9;
        s = (pix * gain + 128) / 256 + off;
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        return 8'(s);
    endfunction

    function automatic logic [15:0] ref_read(input int a);
        case (a)
            0:       return 16'(mdl_en);
            1:       return 16'(mdl_gain);
            2:       return 16'(mdl_off);
            3:       return 16'(mdl_fcnt);
            4:       return 16'(exp_q.size() != 0);
            default: return 16'd0;
        endcase
    endfunction

    task automatic model_reset();
        mdl_en = 0; mdl_gain = 'h100; mdl_off = 0; mdl_fcnt = 0;
        sh_en = 0; sh_gain = 'h100; sh_off = 0;
        exp_q.delete();
        exp_rv = 1'b0; exp_rd = 16'd0;
        prev_stall = 1'b0;
    endtask

    // One clock: observe just before the edge, advance the model, step the clock.
    task automatic tick();
        beat_t       b;
        logic        nxt_rv;
        logic [15:0] nxt_rd;
        if (rand_ready) m_ready = ($urandom_range(0, 9) >= 3);
        #1;
        if (prev_stall) begin
            check_eq("stall_valid", 32'(m_valid), 1);
            check_eq("stall_data", 32'(m_data), 32'(prev_d));
            check_eq("stall_sof", 32'(m_sof), 32'(prev_sof));
            check_eq("stall_eol", 32'(m_eol), 32'(prev_eol));
        end
        prev_stall = m_valid && !m_ready;
        prev_d = m_data; prev_sof = m_sof; prev_eol = m_eol;
        check_eq("rvalid", 32'(cpu_rvalid), 32'(exp_rv));
        check_eq("rdata", 32'(cpu_rdata), 32'(exp_rd));
        nxt_rv = cpu_rd;
        nxt_rd = cpu_rd ? ref_read(int'(cpu_addr)) : 16'd0;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("extra_beat", 32'(exp_q.size()), 1);
            end else begin
                b = exp_q.pop_front();
                check_eq("out_data", 32'(m_data), 32'(b.d));
                check_eq("out_sof", 32'(m_sof), 32'(b.sof));
                check_eq("out_eol", 32'(m_eol), 32'(b.eol));
                if (chk_lat) check_eq("latency", 32'(cyc - b.c), 2);
            end
        end
        last_accept = s_valid && s_ready;
        if (last_accept) begin
            if (s_sof) begin
                sh_en = mdl_en; sh_gain = mdl_gain; sh_off = mdl_off;
                mdl_fcnt = (mdl_fcnt + 1) % 65536;
            end
            b.d = ref_pix(int'(s_data), sh_en, sh_gain, sh_off);
            b.sof = s_sof; b.eol = s_eol; b.c = cyc;
            exp_q.push_back(b);
        end
        if (cpu_wr) begin
            case (cpu_addr)
                3'd0: begin
                    mdl_en = int'(cpu_wdata[0]);
                    if (cpu_wdata[1]) mdl_fcnt = 0;
                end
                3'd1: mdl_gain = int'(cpu_wdata[11:0]);
                3'd2: mdl_off = int'(cpu_wdata[8:0]);
                default: ;
            endcase
        end
        if (rst) begin
            model_reset();
            nxt_rv = 1'b0; nxt_rd = 16'd0;
        end
        exp_rv = nxt_rv; exp_rd = nxt_rd;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [15:0] d);
        cpu_wr = 1'b1; cpu_addr = a; cpu_wdata = d;
        tick();
        cpu_wr = 1'b0;
    endtask

    task automatic reg_rd(input logic [2:0] a, input logic [15:0] want, input string tag);
        cpu_rd = 1'b1; cpu_addr = a;
        tick();
        cpu_rd = 1'b0;
        check_eq(tag, 32'(cpu_rdata), 32'(want));
    endtask

    task automatic send(input int pix, input bit sof, input bit eol);
        s_valid = 1'b1; s_data = 8'(pix); s_sof = sof; s_eol = eol;
        last_accept = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (last_accept) break;
        end
        if (!last_accept) check_eq("send_timeout", 32'(last_accept), 1);
        s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_sof = 1'b0; s_eol = 1'b0;
        m_ready = 1'b1; cpu_addr = '0; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_wdata = '0;
        rand_ready = 1'b0; chk_lat = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_m_valid", 32'(m_valid), 0);
        check_eq("rst_m_data", 32'(m_data), 0);
        check_eq("rst_m_sof", 32'(m_sof), 0);
        check_eq("rst_m_eol", 32'(m_eol), 0);
        check_eq("rst_rvalid", 32'(cpu_rvalid), 0);
        check_eq("rst_rdata", 32'(cpu_rdata), 0);
        check_eq("rst_s_ready", 32'(s_ready), 1);
        rst = 1'b0;

        reg_rd(3'd1, 16'h0100, "gain_reset");
        reg_wr(3'd0, 16'h0001);
        send(0, 1, 0); send(1, 0, 0); send(127, 0, 0); send(255, 0, 1);
        idle(3);
        reg_rd(3'd3, 16'd1, "fcnt_one");

        reg_wr(3'd1, 16'h0180); send(100, 1, 0); send(200, 0, 1);
        reg_wr(3'd1, 16'h0080); send(3, 1, 0); send(1, 0, 1);
        reg_wr(3'd1, 16'h0100); reg_wr(3'd2, 16'h01EC); send(10, 1, 0); send(30, 0, 1);
        reg_wr(3'd2, 16'd100); send(200, 1, 1);

        // Gain change mid-frame only applies from the next sof.
        reg_wr(3'd2, 16'd0);
        send(10, 1, 0); send(20, 0, 0);
        reg_wr(3'd1, 16'h0200);
        send(30, 0, 0); send(40, 0, 1);
        send(50, 1, 0); send(60, 0, 1);

        reg_wr(3'd0, 16'h0000); send(77, 1, 1);
        idle(3);

        // Same-cycle write and read of GAIN returns the old value.
        cpu_wr = 1'b1; cpu_rd = 1'b1; cpu_addr = 3'd1; cpu_wdata = 16'h0123;
        tick();
        cpu_wr = 1'b0; cpu_rd = 1'b0;
        check_eq("wr_rd_old", 32'(cpu_rdata), 32'h200);
        reg_rd(3'd1, 16'h0123, "wr_rd_new");
        reg_wr(3'd7, 16'hFFFF);
        reg_rd(3'd7, 16'd0, "unmapped");

        // Random backpressure over 64x4 frames.
        rand_ready = 1'b1; chk_lat = 1'b0;
        for (int f = 0; f < 2; f++) begin
            reg_wr(3'd1, 16'($urandom_range(0, 'hFFF)));
            reg_wr(3'd2, 16'($urandom_range(0, 'h1FF)));
            reg_wr(3'd0, (f == 0) ? 16'd1 : 16'd0);
            for (int ln = 0; ln < 4; ln++) begin
                for (int px = 0; px < 64; px++) begin
                    if ($urandom_range(0, 3) == 0) tick();
                    send(int'($urandom_range(0, 255)), (ln == 0) && (px == 0), px == 63);
                end
            end
        end
        rand_ready = 1'b0; m_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        check_eq("drain_empty", 32'(exp_q.size()), 0);
        chk_lat = 1'b1;

        // Reset with two beats in flight.
        reg_wr(3'd0, 16'h0001); reg_wr(3'd1, 16'h0200); reg_wr(3'd2, 16'h0005);
        m_ready = 1'b0;
        send(11, 1, 0); send(22, 0, 1);
        rst = 1'b1;
        tick();
        check_eq("flush_m_valid", 32'(m_valid), 0);
        check_eq("flush_s_ready", 32'(s_ready), 1);
        rst = 1'b0; m_ready = 1'b1;
        idle(4);
        reg_rd(3'd0, 16'd0, "post_rst_ctrl");
        reg_rd(3'd1, 16'h0100, "post_rst_gain");
        reg_rd(3'd2, 16'd0, "post_rst_offset");
        reg_rd(3'd3, 16'd0, "post_rst_fcnt");
        reg_rd(3'd4, 16'd0, "post_rst_status");

        send(5, 1, 1);
        reg_rd(3'd4, 16'd1, "status_busy");
        idle(3);
        reg_rd(3'd3, 16'd1, "fcnt_before_clr");
        reg_wr(3'd0, 16'h0002);
        reg_rd(3'd3, 16'd0, "clr");
        cpu_wr = 1'b1; cpu_addr = 3'd0; cpu_wdata = 16'h0003;
        send(6, 1, 1);
        cpu_wr = 1'b0;
        reg_rd(3'd3, 16'd0, "clr_with_sof");
        reg_rd(3'd0, 16'd1, "ctrl_en");
        idle(4);
        check_eq("final_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
